// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Execute-stage multiply/divide unit. Owns the architectural HI/LO
//   registers and executes mult, multu, div, divu, mthi, mtlo, mfhi, mflo.
//   The md operations compute their result at issue, hold it in internal
//   result registers, and commit it to HI/LO after a fixed latency while
//   busy is raised so the hazard unit can stall later MDU instructions.
//
//   Integration note: the D-stage stall is expected to be
//     (D holds an md/mt/mf instruction) && (E.start || busy).
//   The unit has no stall input of its own.
//
// Ports
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous active-high reset, clears all state
//   start  in   1   one-cycle pulse when an md instruction is in E
//   MDUOp  in   4   0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                   5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO
//   A      in  32   rs operand (forwarded)
//   B      in  32   rt operand (forwarded)
//   busy   out  1   operation in flight
//   HI     out 32   architectural HI
//   LO     out 32   architectural LO
//   out    out 32   mf read data (combinational from current HI/LO)
// ---------------------------------------------------------------------------
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t       state_r;
  state_t       state_n;
  logic [15:0]  cnt_r;
  logic [31:0]  hi_r;
  logic [31:0]  lo_r;
  logic [31:0]  res_hi_r;
  logic [31:0]  res_lo_r;
  logic         commit_r;   // cleared for divide-by-zero: completion leaves HI/LO alone

  logic         load_s;
  logic         finish_s;
  logic         is_md_s;
  logic         is_div_s;
  logic [15:0]  cycles_s;

  // Datapath intermediates
  logic [63:0]  prod_signed_s;
  logic [63:0]  prod_unsigned_s;
  logic [31:0]  abs_a_s;
  logic [31:0]  abs_b_s;
  logic [31:0]  safe_b_s;
  logic [31:0]  safe_abs_b_s;
  logic [31:0]  q_mag_s;
  logic [31:0]  r_mag_s;
  logic [31:0]  q_signed_s;
  logic [31:0]  r_signed_s;
  logic [31:0]  q_unsigned_s;
  logic [31:0]  r_unsigned_s;
  logic [31:0]  res_hi_s;
  logic [31:0]  res_lo_s;

  assign busy = (state_r == ST_BUSY);
  assign HI   = hi_r;
  assign LO   = lo_r;

  // Decode of the issued operation class.
  always_comb begin
    is_md_s  = 1'b0;
    is_div_s = 1'b0;
    cycles_s = 16'd0;
    case (MDUOp)
      OP_MULT, OP_MULTU: begin
        is_md_s  = 1'b1;
        cycles_s = 16'(MULT_CYCLES);
      end
      OP_DIV, OP_DIVU: begin
        is_md_s  = 1'b1;
        is_div_s = 1'b1;
        cycles_s = 16'(DIV_CYCLES);
      end
      default: begin
        is_md_s  = 1'b0;
        is_div_s = 1'b0;
        cycles_s = 16'd0;
      end
    endcase
  end

  // Arithmetic: products and quotient/remainder for both signednesses.
  // Signed division works on magnitudes so that 0x80000000 / -1 wraps to
  // 0x80000000 with remainder 0 instead of relying on simulator behaviour.
  always_comb begin
    prod_signed_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_unsigned_s = {32'd0, A} * {32'd0, B};

    if (A[31]) begin
      abs_a_s = 32'd0 - A;
    end else begin
      abs_a_s = A;
    end
    if (B[31]) begin
      abs_b_s = 32'd0 - B;
    end else begin
      abs_b_s = B;
    end

    // Divisor of zero is replaced by one; the result is discarded anyway.
    if (B == 32'd0) begin
      safe_b_s     = 32'd1;
      safe_abs_b_s = 32'd1;
    end else begin
      safe_b_s     = B;
      safe_abs_b_s = abs_b_s;
    end

    q_mag_s      = abs_a_s / safe_abs_b_s;
    r_mag_s      = abs_a_s % safe_abs_b_s;
    q_unsigned_s = A / safe_b_s;
    r_unsigned_s = A % safe_b_s;

    if (A[31] ^ B[31]) begin
      q_signed_s = 32'd0 - q_mag_s;
    end else begin
      q_signed_s = q_mag_s;
    end
    // Remainder takes the sign of the dividend.
    if (A[31]) begin
      r_signed_s = 32'd0 - r_mag_s;
    end else begin
      r_signed_s = r_mag_s;
    end
  end

  // Result selection by operation.
  always_comb begin
    res_hi_s = 32'd0;
    res_lo_s = 32'd0;
    case (MDUOp)
      OP_MULT: begin
        res_hi_s = prod_signed_s[63:32];
        res_lo_s = prod_signed_s[31:0];
      end
      OP_MULTU: begin
        res_hi_s = prod_unsigned_s[63:32];
        res_lo_s = prod_unsigned_s[31:0];
      end
      OP_DIV: begin
        res_hi_s = r_signed_s;
        res_lo_s = q_signed_s;
      end
      OP_DIVU: begin
        res_hi_s = r_unsigned_s;
        res_lo_s = q_unsigned_s;
      end
      default: begin
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
      end
    endcase
  end

  // Control FSM next-state: issue from idle, count down while busy.
  always_comb begin
    state_n  = state_r;
    load_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && is_md_s) begin
          state_n = ST_BUSY;
          load_s  = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // cnt_r <= 1 also covers a zero-latency parameter safely.
        if (cnt_r <= 16'd1) begin
          state_n  = ST_IDLE;
          finish_s = 1'b1;
        end else begin
          state_n = ST_BUSY;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Latency counter and captured results for the operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= 16'd0;
      res_hi_r <= 32'd0;
      res_lo_r <= 32'd0;
      commit_r <= 1'b0;
    end else if (load_s) begin
      cnt_r    <= cycles_s;
      res_hi_r <= res_hi_s;
      res_lo_r <= res_lo_s;
      commit_r <= !(is_div_s && (B == 32'd0));
    end else if (state_r == ST_BUSY) begin
      cnt_r    <= cnt_r - 16'd1;
      res_hi_r <= res_hi_r;
      res_lo_r <= res_lo_r;
      commit_r <= commit_r;
    end else begin
      cnt_r    <= cnt_r;
      res_hi_r <= res_hi_r;
      res_lo_r <= res_lo_r;
      commit_r <= commit_r;
    end
  end

  // Architectural HI/LO: commit at completion, or move-to when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (state_r == ST_BUSY) begin
      if (finish_s && commit_r) begin
        hi_r <= res_hi_r;
        lo_r <= res_lo_r;
      end else begin
        hi_r <= hi_r;
        lo_r <= lo_r;
      end
    end else if (MDUOp == OP_MTHI) begin
      hi_r <= A;
    end else if (MDUOp == OP_MTLO) begin
      lo_r <= A;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // mf read port, straight from the current architectural registers.
  always_comb begin
    out = 32'd0;
    case (MDUOp)
      OP_MFHI: out = hi_r;
      OP_MFLO: out = lo_r;
      default: out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//   Directed self-checking bench for mul_div_unit with hand-computed
//   expected values. Inputs change and outputs are sampled 1 time unit
//   after each rising edge.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] out;

  int checks;
  int passed;

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDUOp (MDUOp),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for a single edge, then return inputs to idle.
  task automatic issue(input logic st, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    start = st;
    MDUOp = op;
    A     = a;
    B     = b;
    tick();
    start = 1'b0;
    MDUOp = 4'd0;
    A     = 32'd0;
    B     = 32'd0;
  endtask

  // Counts busy cycles (bounded), noting whether HI/LO moved meanwhile.
  // With inj set, a start+MULT and an MTHI are driven during busy.
  task automatic wait_busy(input logic [31:0] hi0, input logic [31:0] lo0,
                           input logic inj, output int n, output logic stable);
    n      = 0;
    stable = 1'b1;
    while (busy === 1'b1 && n < 50) begin
      n++;
      if (HI !== hi0 || LO !== lo0) stable = 1'b0;
      if (inj && n == 2) begin
        start = 1'b1; MDUOp = 4'd1; A = 32'd7; B = 32'd7;
      end else if (inj && n == 4) begin
        start = 1'b0; MDUOp = 4'd7; A = 32'h0000DEAD; B = 32'd0;
      end else begin
        start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
      end
      tick();
    end
    start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || out !== 32'd0)
      $display("FAIL reset_state: busy=%0b HI=%h LO=%h out=%h, expected 0/0/0/0", busy, HI, LO, out);
    else passed++;
  endtask

  task automatic test_mt();
    issue(1'b0, 4'd7, 32'h12345678, 32'd0);
    checks++;
    if (HI !== 32'h12345678 || busy !== 1'b0)
      $display("FAIL mthi: HI=%h busy=%0b, expected 12345678/0", HI, busy);
    else passed++;
    issue(1'b0, 4'd8, 32'h9ABCDEF0, 32'd0);
    checks++;
    if (LO !== 32'h9ABCDEF0 || HI !== 32'h12345678 || busy !== 1'b0)
      $display("FAIL mtlo: HI=%h LO=%h busy=%0b, expected 12345678/9abcdef0/0", HI, LO, busy);
    else passed++;
    MDUOp = 4'd5;
    #1;
    checks++;
    if (out !== 32'h12345678)
      $display("FAIL mfhi_out: out=%h, expected 12345678", out);
    else passed++;
    MDUOp = 4'd6;
    #1;
    checks++;
    if (out !== 32'h9ABCDEF0)
      $display("FAIL mflo_out: out=%h, expected 9abcdef0", out);
    else passed++;
    MDUOp = 4'd0;
    #1;
  endtask

  task automatic test_mult();
    int n;
    logic st;
    issue(1'b1, 4'd1, 32'd3, 32'hFFFFFFFE);
    wait_busy(32'h12345678, 32'h9ABCDEF0, 1'b0, n, st);
    checks++;
    if (n !== 5 || st !== 1'b1)
      $display("FAIL mult_busy: cycles=%0d stable=%0b, expected 5/1", n, st);
    else passed++;
    checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA)
      $display("FAIL mult_result: HI=%h LO=%h, expected ffffffff/fffffffa", HI, LO);
    else passed++;
  endtask

  task automatic test_multu();
    int n;
    logic st;
    issue(1'b1, 4'd2, 32'hFFFFFFFF, 32'd2);
    wait_busy(32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, n, st);
    checks++;
    if (n !== 5 || st !== 1'b1 || HI !== 32'h00000001 || LO !== 32'hFFFFFFFE)
      $display("FAIL multu: cycles=%0d stable=%0b HI=%h LO=%h, expected 5/1/00000001/fffffffe", n, st, HI, LO);
    else passed++;
  endtask

  task automatic test_div();
    int n;
    logic st;
    issue(1'b1, 4'd3, 32'hFFFFFFF9, 32'd2);
    wait_busy(32'h00000001, 32'hFFFFFFFE, 1'b0, n, st);
    checks++;
    if (n !== 10 || st !== 1'b1)
      $display("FAIL div_busy: cycles=%0d stable=%0b, expected 10/1", n, st);
    else passed++;
    checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD)
      $display("FAIL div_neg: HI=%h LO=%h, expected ffffffff/fffffffd", HI, LO);
    else passed++;
    issue(1'b1, 4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_busy(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, n, st);
    checks++;
    if (n !== 10 || HI !== 32'h00000000 || LO !== 32'h80000000)
      $display("FAIL div_overflow: cycles=%0d HI=%h LO=%h, expected 10/00000000/80000000", n, HI, LO);
    else passed++;
    // 100 / 7 unsigned = 14 remainder 2
    issue(1'b1, 4'd4, 32'd100, 32'd7);
    wait_busy(32'h00000000, 32'h80000000, 1'b0, n, st);
    checks++;
    if (n !== 10 || HI !== 32'd2 || LO !== 32'd14)
      $display("FAIL divu: cycles=%0d HI=%h LO=%h, expected 10/00000002/0000000e", n, HI, LO);
    else passed++;
    // 7 / -2 signed = -3 remainder 1 (remainder follows dividend)
    issue(1'b1, 4'd3, 32'd7, 32'hFFFFFFFE);
    wait_busy(32'd2, 32'd14, 1'b0, n, st);
    checks++;
    if (HI !== 32'd1 || LO !== 32'hFFFFFFFD)
      $display("FAIL div_pos_by_neg: HI=%h LO=%h, expected 00000001/fffffffd", HI, LO);
    else passed++;
  endtask

  task automatic test_div_zero();
    int n;
    logic st;
    issue(1'b0, 4'd7, 32'd5, 32'd0);
    issue(1'b0, 4'd8, 32'd6, 32'd0);
    issue(1'b1, 4'd4, 32'd1234, 32'd0);
    wait_busy(32'd5, 32'd6, 1'b1, n, st);
    checks++;
    if (n !== 10 || st !== 1'b1)
      $display("FAIL divzero_busy: cycles=%0d stable=%0b, expected 10/1", n, st);
    else passed++;
    checks++;
    if (HI !== 32'd5 || LO !== 32'd6)
      $display("FAIL divzero_keep: HI=%h LO=%h, expected 00000005/00000006", HI, LO);
    else passed++;
    // Injected start must not have launched a hidden operation.
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || HI !== 32'd5 || LO !== 32'd6)
      $display("FAIL inject_ignored: busy=%0b HI=%h LO=%h, expected 0/00000005/00000006", busy, HI, LO);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    logic st;
    issue(1'b1, 4'd1, 32'd7, 32'd7);
    tick();            // busy cycle 2
    tick();            // busy cycle 3
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
      $display("FAIL reset_mid: busy=%0b HI=%h LO=%h, expected 0/0/0", busy, HI, LO);
    else passed++;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
      $display("FAIL no_stale_commit: busy=%0b HI=%h LO=%h, expected 0/0/0", busy, HI, LO);
    else passed++;
    issue(1'b1, 4'd1, 32'd7, 32'd6);
    wait_busy(32'd0, 32'd0, 1'b0, n, st);
    checks++;
    if (n !== 5 || HI !== 32'd0 || LO !== 32'd42)
      $display("FAIL mult_after_reset: cycles=%0d HI=%h LO=%h, expected 5/0/0000002a", n, HI, LO);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    logic st;
    // mflo straight after completion sees the new value; then an mthi.
    MDUOp = 4'd6;
    #1;
    checks++;
    if (out !== 32'd42)
      $display("FAIL mflo_after_commit: out=%h, expected 0000002a", out);
    else passed++;
    issue(1'b0, 4'd7, 32'hCAFEF00D, 32'd0);
    issue(1'b1, 4'd2, 32'h00010000, 32'h00010000);
    wait_busy(32'hCAFEF00D, 32'd42, 1'b0, n, st);
    checks++;
    if (n !== 5 || st !== 1'b1 || HI !== 32'd1 || LO !== 32'd0)
      $display("FAIL multu_b2b: cycles=%0d stable=%0b HI=%h LO=%h, expected 5/1/00000001/00000000", n, st, HI, LO);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset  = 1'b0;
    start  = 1'b0;
    MDUOp  = 4'd0;
    A      = 32'd0;
    B      = 32'd0;
    test_reset();
    test_mt();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Execute-stage multiply/divide unit that carries out the MDU operations issued by the instruction decoder: mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- It owns the architectural HI and LO registers.
- It models a multi-cycle latency and raises busy so the hazard unit can stall D-stage MDU instructions.
- Inputs come from the E-stage pipeline register (start, MDUOp, forwarded rs/rt values). The mf result feeds the E-to-M forwarding and writeback path.

Parameters:
- MULT_CYCLES, default 5: busy duration in cycles for mult/multu.
- DIV_CYCLES, default 10: busy duration in cycles for div/divu.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  high for one cycle when an md instruction (mult/multu/div/divu) is in E.
- MDUOp  input  4  operation code: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO.
- A  input  32  rs operand, already forwarded.
- B  input  32  rt operand, already forwarded.
- busy  output  1  high while an operation is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- out  output  32  mf read data: HI when MDUOp=5, LO when MDUOp=6, else 0. Purely combinational from the current HI/LO.

Behaviour:
- **Reset:** at a clock edge with reset=1, HI=0, LO=0, busy=0, counter=0 and internal result registers=0. Reset takes priority over everything, including an operation in flight, which is abandoned with no HI/LO commit.
- **Idle (busy=0):**
  - At an edge with start=1 and MDUOp in 1..4, compute the result into internal registers resHI/resLO, load the counter with MULT_CYCLES or DIV_CYCLES, and set busy=1.
  - start=1 with any other MDUOp is ignored.
- **Busy:**
  - Decrement the counter at each edge.
  - At the edge where the counter goes from 1 to 0, commit HI<=resHI, LO<=resLO and clear busy in that same edge.
  - busy is therefore high for exactly N cycles, starting the cycle after start.
  - New results are visible on HI/LO in the first cycle with busy=0.
- **start or MTHI/MTLO while busy:** ignored, state is unchanged. The hazard unit guarantees this never happens; the block must still not corrupt state if it does.
- **MTHI/MTLO:**
  - When busy=0 and MDUOp=7, HI<=A at the edge. When busy=0 and MDUOp=8, LO<=A at the edge.
  - Single-cycle; busy is never asserted.
  - start is 0 for these ops.
- **mult:** signed 32x32 multiply to a 64-bit product; HI = product[63:32], LO = product[31:0].
- **multu:** the same multiply, unsigned.
- **div:** signed division with the quotient truncated toward zero.
  - LO = quotient; HI = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **divu:** unsigned division; LO = quotient, HI = remainder.
- **Divide by zero (B=0) for div/divu:**
  - busy is still asserted for DIV_CYCLES.
  - At completion HI and LO keep the values they held when the operation started; nothing is committed.
- **out:** combinational. It is valid during busy but reflects the old HI/LO; the stall logic prevents an mf from reaching E while busy.
- **Stall contract (external, documented for integration):**
  - D-stage stall = D is an md/mt/mf instruction AND (E.start OR busy).
  - The block itself has no stall input.

Test Plan:
1. **Reset, then mthi/mtlo:** reset, then MDUOp=7 with A=0x12345678, then MDUOp=8 with A=0x9ABCDEF0 → HI=0x12345678, LO=0x9ABCDEF0 one cycle after each op; busy stays 0; MDUOp=5 gives out=0x12345678.
2. **Signed mult:** start with MDUOp=1, A=3, B=0xFFFFFFFE → busy high for exactly 5 cycles; the next cycle shows HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO are unchanged while busy.
3. **Unsigned mult:** start with MDUOp=2, A=0xFFFFFFFF, B=2 → after 5 busy cycles, HI=0x00000001, LO=0xFFFFFFFE.
4. **Signed div and overflow case:**
   - start with MDUOp=3, A=0xFFFFFFF9 (-7), B=2 → busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - Repeat with A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
5. **Divide by zero, and start while busy:**
   - Preload HI=5, LO=6, then start with MDUOp=4, B=0 → busy for 10 cycles; HI=5, LO=6 afterwards.
   - During busy, inject start with MDUOp=1 and MDUOp=7 → both ignored, and busy timing is unchanged.
6. **Reset mid-operation:** start mult 7×7 and assert reset in busy cycle 3 → the next cycle shows busy=0, HI=0, LO=0, and 49 is never committed. A following mult completes normally.
